// File: rtl/ps2_matrix.sv
// ps2_matrix: PS/2 byte-stream parser that maps make/break events through a
// loadable map RAM into a ROWS x COLS key matrix read by the host row scan.
module ps2_matrix #(
  parameter int unsigned ROWS        = 10,
  parameter int unsigned COLS        = 8,
  parameter logic [7:0]  HOTKEY_CODE = 8'h78,
  parameter int unsigned PAUSE_SKIP  = 7
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0]      code,
  input  logic            strobe,
  input  logic            map_we,
  input  logic [8:0]      map_addr,
  input  logic [7:0]      map_data,
  input  logic [3:0]      row,
  output logic [COLS-1:0] q,
  output logic            hotkey
);

  localparam int unsigned SKIP_W    = $clog2(PAUSE_SKIP + 1);
  localparam int unsigned MAP_DEPTH = 512;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXT     = 3'd1,
    BRK     = 3'd2,
    EXT_BRK = 3'd3,
    SKIP    = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [SKIP_W-1:0]          skip_q, skip_d;
  logic                       ev_c, ev_ext_c, ev_make_c;
  logic                       clr_c, hot_set_c, hot_clr_c;
  logic                       pend_q, make_q;
  logic [7:0]                 ent_q;
  logic                       hotkey_q;
  logic [ROWS-1:0][COLS-1:0]  key_q;
  logic [7:0]                 map_mem [MAP_DEPTH];

  logic       ent_valid;
  logic [3:0] ent_row;
  logic [2:0] ent_col;

  assign ent_valid = ent_q[7];
  assign ent_row   = ent_q[6:3];
  assign ent_col   = ent_q[2:0];
  assign hotkey    = hotkey_q;

  // Parser next-state and per-byte event decode.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    ev_c      = 1'b0;
    ev_ext_c  = 1'b0;
    ev_make_c = 1'b0;
    clr_c     = 1'b0;
    hot_set_c = 1'b0;
    hot_clr_c = 1'b0;
    if (strobe) begin
      case (state_q)
        IDLE: begin
          case (code)
            8'hE0: state_d = EXT;
            8'hF0: state_d = BRK;
            8'hE1: begin
              state_d = SKIP;
              skip_d  = SKIP_W'(PAUSE_SKIP);
            end
            8'hAA: clr_c = 1'b1;
            8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
            default: begin
              ev_c      = 1'b1;
              ev_make_c = 1'b1;
              hot_set_c = (code == HOTKEY_CODE);
            end
          endcase
        end
        EXT: begin
          if (code == 8'hF0) begin
            state_d = EXT_BRK;
          end else begin
            ev_c      = 1'b1;
            ev_ext_c  = 1'b1;
            ev_make_c = 1'b1;
            state_d   = IDLE;
          end
        end
        BRK: begin
          ev_c      = 1'b1;
          hot_clr_c = (code == HOTKEY_CODE);
          state_d   = IDLE;
        end
        EXT_BRK: begin
          ev_c     = 1'b1;
          ev_ext_c = 1'b1;
          state_d  = IDLE;
        end
        SKIP: begin
          skip_d = skip_q - SKIP_W'(1);
          if (skip_q <= SKIP_W'(1)) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Parser state, pending-event pipeline stage and hotkey flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      skip_q   <= '0;
      pend_q   <= 1'b0;
      make_q   <= 1'b0;
      hotkey_q <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      pend_q  <= ev_c;
      make_q  <= ev_make_c;
      if (clr_c || hot_clr_c) hotkey_q <= 1'b0;
      else if (hot_set_c)     hotkey_q <= 1'b1;
    end
  end

  // Map RAM: host writes, lookup reads the old entry on a same-cycle collision.
  always_ff @(posedge clock) begin
    if (map_we) map_mem[map_addr] <= map_data;
    ent_q <= map_mem[{ev_ext_c, code}];
  end

  // Key matrix: bulk clear beats the pending event; out-of-range targets drop.
  always_ff @(posedge clock) begin
    if (reset || clr_c) begin
      key_q <= '0;
    end else if (pend_q && ent_valid) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (ent_row == 4'(r) && ent_col == 3'(c)) key_q[r][c] <= make_q;
        end
      end
    end
  end

  // Active-low column readout for the scanned row; unpopulated rows read idle.
  always_comb begin
    q = '1;
    for (int r = 0; r < ROWS; r++) begin
      if (row == 4'(r)) q = ~key_q[r];
    end
  end

endmodule
